// File: rtl/icache_pkg.sv
// ============================================================================
// Module  : icache_pkg
// Brief   : Shared geometry defaults, derived widths and refill FSM encoding
//           for the instruction-cache refill path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    localparam int unsigned C_OFFSET_WIDTH = 2;
    localparam int unsigned C_LINE_WIDTH   = 6;

    function automatic int unsigned tag_width_of(input int unsigned off_w, input int unsigned line_w);
        return 30 - off_w - line_w;
    endfunction

    function automatic int unsigned block_size_of(input int unsigned off_w);
        return 1 << off_w;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
// ============================================================================
// Module  : icache_refill_ctrl
// Brief   : Fetches a missing I-cache block word-by-word over a valid/ready
//           memory port and writes it into the cache array in one fill cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned OFFSET_WIDTH = C_OFFSET_WIDTH,
    parameter int unsigned LINE_WIDTH   = C_LINE_WIDTH,
    localparam int unsigned TAG_WIDTH   = tag_width_of(OFFSET_WIDTH, LINE_WIDTH),
    localparam int unsigned BLOCK_SIZE  = block_size_of(OFFSET_WIDTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     miss_valid,
    input  logic [31:0]              miss_address,
    output logic                     miss_ready,
    input  logic                     abort,
    output logic                     mem_req_valid,
    output logic [31:0]              mem_req_addr,
    input  logic                     mem_req_ready,
    input  logic                     mem_resp_valid,
    input  logic [31:0]              mem_resp_data,
    output logic                     write_in,
    output logic [LINE_WIDTH-1:0]    write_line_index,
    output logic [32*BLOCK_SIZE-1:0] write_block,
    output logic [TAG_WIDTH-1:0]     write_tag,
    output logic                     busy
);

    localparam int unsigned C_BLK_ADDR_W = 30 - OFFSET_WIDTH;

    state_t                   r_state;
    logic [OFFSET_WIDTH-1:0]  r_cnt;
    logic [C_BLK_ADDR_W-1:0]  r_block_addr;
    logic [31:0]              r_buf [BLOCK_SIZE];
    logic                     r_write_in;
    logic [32*BLOCK_SIZE-1:0] r_write_block;
    logic [TAG_WIDTH-1:0]     r_write_tag;
    logic [LINE_WIDTH-1:0]    r_write_index;

    logic [OFFSET_WIDTH-1:0]  w_cnt_next;
    logic                     w_unused;

    // Counter wraps inside the block, so the request address never carries into index/tag.
    assign w_cnt_next = r_cnt + OFFSET_WIDTH'(1);
    assign w_unused   = &{1'b0, miss_address[OFFSET_WIDTH+1:0]};

    assign miss_ready       = (r_state == ST_IDLE);
    assign busy             = (r_state != ST_IDLE);
    assign mem_req_valid    = (r_state == ST_REQ);
    assign mem_req_addr     = (r_state == ST_REQ) ? {r_block_addr, r_cnt, 2'b00} : 32'd0;
    assign write_in         = r_write_in;
    assign write_block      = r_write_block;
    assign write_tag        = r_write_tag;
    assign write_line_index = r_write_index;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_block_addr  <= '0;
            r_write_in    <= 1'b0;
            r_write_block <= '0;
            r_write_tag   <= '0;
            r_write_index <= '0;
        end else begin
            r_write_in <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (miss_valid) begin
                        r_block_addr <= miss_address[31:OFFSET_WIDTH+2];
                        r_cnt        <= '0;
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An accepted request must still have its response drained.
                    if (mem_req_ready) begin
                        r_state <= abort ? ST_DRAIN : ST_WAIT;
                    end else if (abort) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        r_state <= mem_resp_valid ? ST_IDLE : ST_DRAIN;
                    end else if (mem_resp_valid) begin
                        r_buf[r_cnt] <= mem_resp_data;
                        if (&r_cnt) begin
                            r_state       <= ST_COMMIT;
                            r_write_in    <= 1'b1;
                            r_write_tag   <= r_block_addr[C_BLK_ADDR_W-1:LINE_WIDTH];
                            r_write_index <= r_block_addr[LINE_WIDTH-1:0];
                            for (int j = 0; j < BLOCK_SIZE; j++) begin
                                r_write_block[32*j +: 32] <= (j == BLOCK_SIZE-1) ? mem_resp_data : r_buf[j];
                            end
                        end else begin
                            r_cnt   <= w_cnt_next;
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (mem_resp_valid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
// ============================================================================
// Module  : tb_icache_refill_ctrl
// Brief   : Directed self-checking bench for the I-cache refill controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_refill_ctrl;

    logic         clock;
    logic         reset;
    logic         miss_valid;
    logic [31:0]  miss_address;
    logic         miss_ready;
    logic         abort;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [31:0]  mem_resp_data;
    logic         write_in;
    logic [5:0]   write_line_index;
    logic [127:0] write_block;
    logic [21:0]  write_tag;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0;

    icache_refill_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .miss_valid       (miss_valid),
        .miss_address     (miss_address),
        .miss_ready       (miss_ready),
        .abort            (abort),
        .mem_req_valid    (mem_req_valid),
        .mem_req_addr     (mem_req_addr),
        .mem_req_ready    (mem_req_ready),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .write_in         (write_in),
        .write_line_index (write_line_index),
        .write_block      (write_block),
        .write_tag        (write_tag),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_miss(input logic [31:0] addr, input bit hold);
        miss_valid   = 1'b1;
        miss_address = addr;
        chk("miss_ready_before_accept", 128'(miss_ready), 128'd1);
        t0 = cyc;
        tick();
        if (!hold) miss_valid = 1'b0;
        chk("busy_after_accept", 128'(busy), 128'd1);
    endtask

    // One word: optional ready stall, handshake, response in the following cycle.
    task automatic do_word(input logic [31:0] exp_addr, input logic [31:0] data, input int stall);
        chk("req_valid", 128'(mem_req_valid), 128'd1);
        chk("req_addr", 128'(mem_req_addr), 128'(exp_addr));
        for (int s = 0; s < stall; s++) begin
            mem_req_ready = 1'b0;
            tick();
            chk("stall_req_valid", 128'(mem_req_valid), 128'd1);
            chk("stall_req_addr", 128'(mem_req_addr), 128'(exp_addr));
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("wait_req_valid_low", 128'(mem_req_valid), 128'd0);
        chk("wait_no_write", 128'(write_in), 128'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        miss_valid     = 1'b0;
        miss_address   = 32'd0;
        abort          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
        tick();
        tick();
        chk("rst_miss_ready", 128'(miss_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_req_valid", 128'(mem_req_valid), 128'd0);
        chk("rst_write_in", 128'(write_in), 128'd0);
        reset = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ignored", 128'(miss_ready), 128'd1);

        // 1: basic refill
        start_miss(32'h0000_1234, 1'b0);
        do_word(32'h0000_1230, 32'hA0, 0);
        do_word(32'h0000_1234, 32'hA1, 0);
        do_word(32'h0000_1238, 32'hA2, 0);
        do_word(32'h0000_123C, 32'hA3, 0);
        chk("t1_write_in", 128'(write_in), 128'd1);
        chk("t1_latency", 128'(cyc - t0), 128'd9);
        chk("t1_index", 128'(write_line_index), 128'h23);
        chk("t1_tag", 128'(write_tag), 128'h4);
        chk("t1_block", write_block, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("t1_commit_not_ready", 128'(miss_ready), 128'd0);
        tick();
        chk("t1_write_in_one_cycle", 128'(write_in), 128'd0);
        chk("t1_ready_again", 128'(miss_ready), 128'd1);
        chk("t1_block_held", write_block, 128'h000000A3_000000A2_000000A1_000000A0);

        // 2: ready stall on word 1
        start_miss(32'h0000_1234, 1'b0);
        do_word(32'h0000_1230, 32'hB0, 0);
        do_word(32'h0000_1234, 32'hB1, 3);
        do_word(32'h0000_1238, 32'hB2, 0);
        do_word(32'h0000_123C, 32'hB3, 0);
        chk("t2_write_in", 128'(write_in), 128'd1);
        chk("t2_latency", 128'(cyc - t0), 128'd12);
        chk("t2_block", write_block, 128'h000000B3_000000B2_000000B1_000000B0);
        tick();

        // 3: abort while waiting for word 2
        start_miss(32'h0000_2000, 1'b0);
        do_word(32'h0000_2000, 32'h11, 0);
        do_word(32'h0000_2004, 32'h22, 0);
        chk("t3_req_addr", 128'(mem_req_addr), 128'h2008);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_drain_busy", 128'(busy), 128'd1);
        chk("t3_drain_not_ready", 128'(miss_ready), 128'd0);
        tick();
        chk("t3_drain_busy2", 128'(busy), 128'd1);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h33;
        tick();
        mem_resp_valid = 1'b0;
        chk("t3_idle_ready", 128'(miss_ready), 128'd1);
        chk("t3_no_write", 128'(write_in), 128'd0);
        chk("t3_block_unchanged", write_block, 128'h000000B3_000000B2_000000B1_000000B0);

        // 4: reset while requesting word 3
        start_miss(32'h0000_3000, 1'b0);
        do_word(32'h0000_3000, 32'h44, 0);
        do_word(32'h0000_3004, 32'h55, 0);
        do_word(32'h0000_3008, 32'h66, 0);
        chk("t4_req_addr", 128'(mem_req_addr), 128'h300C);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_ready", 128'(miss_ready), 128'd1);
        chk("t4_busy", 128'(busy), 128'd0);
        chk("t4_req_valid", 128'(mem_req_valid), 128'd0);
        chk("t4_req_addr_zero", 128'(mem_req_addr), 128'd0);
        chk("t4_block_zero", write_block, 128'd0);
        chk("t4_tag_zero", 128'(write_tag), 128'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h77;
        tick();
        mem_resp_valid = 1'b0;
        chk("t4_late_resp_busy", 128'(busy), 128'd0);
        chk("t4_late_resp_write", 128'(write_in), 128'd0);

        // 5: top-of-memory block, abort during fill cycle
        start_miss(32'hFFFF_FFFC, 1'b0);
        do_word(32'hFFFF_FFF0, 32'hC0, 0);
        do_word(32'hFFFF_FFF4, 32'hC1, 0);
        do_word(32'hFFFF_FFF8, 32'hC2, 0);
        do_word(32'hFFFF_FFFC, 32'hC3, 0);
        chk("t5_write_in", 128'(write_in), 128'd1);
        chk("t5_index", 128'(write_line_index), 128'h3F);
        chk("t5_tag", 128'(write_tag), 128'h3F_FFFF);
        chk("t5_block", write_block, 128'h000000C3_000000C2_000000C1_000000C0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_ready_after", 128'(miss_ready), 128'd1);

        // 6: back-to-back misses with miss_valid held
        start_miss(32'h0000_4440, 1'b1);
        do_word(32'h0000_4440, 32'hD0, 0);
        do_word(32'h0000_4444, 32'hD1, 0);
        do_word(32'h0000_4448, 32'hD2, 0);
        do_word(32'h0000_444C, 32'hD3, 0);
        chk("t6_first_write", 128'(write_in), 128'd1);
        chk("t6_first_block", write_block, 128'h000000D3_000000D2_000000D1_000000D0);
        chk("t6_commit_not_ready", 128'(miss_ready), 128'd0);
        tick();
        chk("t6_idle_ready", 128'(miss_ready), 128'd1);
        chk("t6_idle_no_write", 128'(write_in), 128'd0);
        tick();
        miss_valid = 1'b0;
        chk("t6_second_accepted", 128'(busy), 128'd1);
        do_word(32'h0000_4440, 32'hE0, 0);
        do_word(32'h0000_4444, 32'hE1, 0);
        do_word(32'h0000_4448, 32'hE2, 0);
        do_word(32'h0000_444C, 32'hE3, 0);
        chk("t6_second_write", 128'(write_in), 128'd1);
        chk("t6_second_index", 128'(write_line_index), 128'h04);
        chk("t6_second_tag", 128'(write_tag), 128'h11);
        chk("t6_second_block", write_block, 128'h000000E3_000000E2_000000E1_000000E0);
        tick();
        chk("t6_end_no_write", 128'(write_in), 128'd0);
        tick();
        chk("t6_no_third_accept", 128'(busy), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
